moving_sum_decoder: RTL and testbench
=====================================

MOVING_SUM_DECODER -- requirements
Module: moving_sum_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, recovered sample width (two's complement).
REQ-002 SHALL have parameter SIZE, default 6, window length of the moving sum being inverted (>=1).
REQ-003 SHALL derive local constant IW = WIDTH + ceil(log2(SIZE+1)), the moving-sum input width (11 for defaults).
REQ-004 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-low reset (reset==0 resets on next clk edge).
REQ-006 SHALL have ports: clear  in  1  synchronous state clear, active-high.
REQ-007 SHALL have ports: i_tdata  in  IW  signed moving-sum sample; i_tvalid  in  1; i_tready  out  1.
REQ-008 SHALL have ports: o_tdata  out  WIDTH  recovered signed sample; o_tvalid  out  1; o_tready  in  1.

Function
REQ-009 SHALL invert a SIZE-window moving sum: x[n] = y[n] - y[n-1] + x[n-SIZE], with y[-1]=0 and x[k<0]=0 after reset/clear.
REQ-010 SHALL compute modulo 2^IW and output the low WIDTH bits; result is exact for any encoder output, including wrapped sums.
REQ-011 SHALL hold the last SIZE recovered samples in a circular history buffer with write/read pointer wrapping SIZE-1 -> 0.
REQ-012 SHALL hold previous input y[n-1] in an IW-bit register, updated only on accepted input.
REQ-013 SHALL accept input on clk edge where i_tvalid & i_tready; history, pointer and y[n-1] advance only then.
REQ-014 SHALL drive i_tready = reset & ~clear & (~o_tvalid | o_tready) (single output register, full throughput).
REQ-015 SHALL have latency exactly 1 clk: sample accepted at edge k is presented on o_tdata with o_tvalid=1 after edge k.
REQ-016 SHALL hold o_tdata and o_tvalid stable while o_tvalid & ~o_tready.
REQ-017 SHALL deassert o_tvalid on the edge where output is consumed and no new input is accepted.
REQ-018 SHALL, on clear=1: zero history, y[n-1], pointer; o_tvalid->0; any same-cycle input is dropped (clear wins).
REQ-019 SHALL sustain one sample per clk indefinitely, with no stall at pointer wrap.

Reset
REQ-020 SHALL, while reset==0, on each clk edge: o_tvalid=0, o_tdata=0, history=0, y[n-1]=0, pointer=0; i_tready=0.
REQ-021 SHALL treat reset mid-operation as in REQ-020: in-flight output discarded, no partial state kept.
REQ-022 SHALL give reset priority over clear; first accepted sample after release decodes as n=0.

Structure
REQ-023 SHALL take the IW width function (ceil log2) from the shared dsp package/header, used by BoundedIntegrator too.
REQ-024 SHALL implement history as one sub-module sample_ring (SIZE x WIDTH, push/read-oldest, clear, wrapping pointer).
REQ-025 SHALL keep the subtract/add datapath and handshake in moving_sum_decoder; no other sub-modules.

Verification (WIDTH=8, SIZE=6)
REQ-026 SHALL check: inputs 0x07F,0x7FF,0x07E,0x7FE,0x07D,0x7FD,0x7FD,... -> outputs 0x7F,0x80,0x7F,0x80,..., each 1 clk after acceptance.
REQ-027 SHALL check: step inputs 127,254,381,508,635,762,762,762 -> output 0x7F every sample, including at pointer wrap.
REQ-028 SHALL check: o_tready=0 for 3 clks during stream -> o_tdata/o_tvalid frozen, i_tready=0, and no samples lost or duplicated afterwards.
REQ-029 SHALL check: clear=1 for 1 clk mid-stream with i_tvalid=1, then replay REQ-026 sequence -> identical outputs as from reset.
REQ-030 SHALL check: reset=0 for 2 clks mid-stream -> o_tvalid=0 and i_tready=0 during reset, decoding restarts at n=0.
REQ-031 SHALL check: 400-sample ramp 0x00..0x8F (wrapping) through a BoundedIntegrator golden model with random o_tready -> output equals original ramp.

Source files
------------

// File: rtl/moving_sum_decoder_pkg.sv
// -----------------------------------------------------------------------------
// moving_sum_decoder_pkg
// Shared DSP helpers. The moving-sum encoder (BoundedIntegrator) and this
// decoder both size their sum datapath with msd_sum_width(), so the two sides
// always agree on the modulus.
// -----------------------------------------------------------------------------
package moving_sum_decoder_pkg;

    // Ceiling log2 for elaboration-time sizing. Returns 0 for v <= 1.
    function automatic int msd_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of a SIZE-window moving sum of WIDTH-bit samples.
    function automatic int msd_sum_width(input int width, input int size);
        return width + msd_clog2(size + 1);
    endfunction

    // History pointer width. It is kept at least 1 bit wide so that SIZE==1
    // still has a legal pointer register.
    function automatic int msd_ptr_width(input int size);
        return (size > 1) ? msd_clog2(size) : 1;
    endfunction

    localparam int MSD_DEF_WIDTH = 8;
    localparam int MSD_DEF_SIZE  = 6;

endpackage

// File: rtl/moving_sum_decoder_if.sv
// -----------------------------------------------------------------------------
// moving_sum_decoder_if
// Streaming bus into and out of moving_sum_decoder.
//   i_tdata  [IW]    moving-sum sample (two's complement)
//   i_tvalid/i_tready  input handshake
//   o_tdata  [WIDTH] recovered sample (two's complement)
//   o_tvalid/o_tready  output handshake
// modport slave  : decoder side
// modport master : source/sink side (testbench or upstream/downstream logic)
// -----------------------------------------------------------------------------
interface moving_sum_decoder_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 6
) ();
    import moving_sum_decoder_pkg::*;

    localparam int IW = msd_sum_width(WIDTH, SIZE);

    logic [IW-1:0]    i_tdata;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tready;

    modport slave (
        input  i_tdata, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tvalid
    );

    modport master (
        output i_tdata, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tvalid
    );

endinterface

// File: rtl/moving_sum_decoder_sample_ring.sv
// -----------------------------------------------------------------------------
// sample_ring
// Circular history of the last SIZE recovered samples.
//   clk      clock (rising edge)
//   reset    synchronous active-low reset
//   i_clear  synchronous clear (active-high)
//   i_push   write i_data at the pointer and advance it
//   i_data   [WIDTH] sample to store
//   o_oldest [WIDTH] sample pushed SIZE pushes ago (0 until that many pushes)
// The slot under the pointer is both the oldest entry and the next slot to be
// overwritten, so one pointer serves as read and write pointer.
// -----------------------------------------------------------------------------
module sample_ring
    import moving_sum_decoder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_oldest
);

    localparam int PW = msd_ptr_width(SIZE);

    logic [SIZE-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]              r_ptr;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_mem <= '0;
            r_ptr <= '0;
        end else if (i_push) begin
            r_mem[r_ptr] <= i_data;
            r_ptr        <= (r_ptr == PW'(SIZE - 1)) ? '0 : r_ptr + PW'(1);
        end
    end

    assign o_oldest = r_mem[r_ptr];

endmodule

// File: rtl/moving_sum_decoder.sv
// -----------------------------------------------------------------------------
// moving_sum_decoder
// Inverts a SIZE-window moving sum: x[n] = y[n] - y[n-1] + x[n-SIZE].
// The arithmetic is done modulo 2^IW, so the result is exact even when the
// encoder's sum wrapped; the low WIDTH bits are the recovered sample.
//   clk    clock (rising edge)
//   reset  synchronous active-low reset (takes priority over clear)
//   clear  synchronous state clear, active-high; drops same-cycle input
//   bus    moving_sum_decoder_if.slave: i_tdata/i_tvalid/i_tready in,
//          o_tdata/o_tvalid/o_tready out
// One output register, latency 1 clk, full throughput.
// -----------------------------------------------------------------------------
module moving_sum_decoder
    import moving_sum_decoder_pkg::*;
#(
    parameter int WIDTH = MSD_DEF_WIDTH,
    parameter int SIZE  = MSD_DEF_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    moving_sum_decoder_if.slave  bus
);

    localparam int IW = msd_sum_width(WIDTH, SIZE);

    logic [IW-1:0]    r_y_prev;
    logic [WIDTH-1:0] r_o_tdata;
    logic             r_o_tvalid;

    logic             w_in_fire;
    logic [WIDTH-1:0] w_oldest;
    logic [IW-1:0]    w_oldest_ext;
    logic [WIDTH-1:0] w_x;

    // Ready is gated by reset and clear, so an accepted input never coincides
    // with a reset or clear edge. This is why "clear wins" holds without extra
    // logic.
    assign bus.i_tready = reset & ~clear & (~r_o_tvalid | bus.o_tready);
    assign w_in_fire    = bus.i_tvalid & bus.i_tready;

    sample_ring #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (clear),
        .i_push   (w_in_fire),
        .i_data   (w_x),
        .o_oldest (w_oldest)
    );

    // x[n-SIZE] is sign-extended to the sum width. Only the low WIDTH bits of
    // the result are kept, and modular arithmetic makes them exact.
    assign w_oldest_ext = {{(IW - WIDTH){w_oldest[WIDTH-1]}}, w_oldest};
    assign w_x          = WIDTH'(bus.i_tdata - r_y_prev + w_oldest_ext);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_y_prev   <= '0;
            r_o_tdata  <= '0;
            r_o_tvalid <= 1'b0;
        end else if (clear) begin
            r_y_prev   <= '0;
            r_o_tvalid <= 1'b0;
        end else if (w_in_fire) begin
            r_y_prev   <= bus.i_tdata;
            r_o_tdata  <= w_x;
            r_o_tvalid <= 1'b1;
        end else if (bus.o_tready) begin
            r_o_tvalid <= 1'b0;
        end
    end

    assign bus.o_tdata  = r_o_tdata;
    assign bus.o_tvalid = r_o_tvalid;

endmodule

// File: tb/tb_moving_sum_decoder.sv
module tb_moving_sum_decoder;

    localparam int WIDTH = 8;
    localparam int SIZE  = 6;
    localparam int IW    = 11;
    localparam int NRAMP = 400;

    logic clk;
    logic reset;
    logic clear;
    int   checks;
    int   failures;

    moving_sum_decoder_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    moving_sum_decoder #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0]    alt_in  [8];
    logic [WIDTH-1:0] alt_exp [8];
    logic [IW-1:0]    step_in [8];
    logic [IW-1:0]    ramp_in [NRAMP];
    logic [WIDTH-1:0] ramp_exp[NRAMP];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset        = 1'b0;
        bus.i_tvalid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = 11'h07F;
        bus.o_tready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (bus.o_tvalid !== 1'b0) begin
            failures++; $display("FAIL reset_o_tvalid got=%b exp=0", bus.o_tvalid);
        end
        checks++;
        if (bus.o_tdata !== 8'h00) begin
            failures++; $display("FAIL reset_o_tdata got=%h exp=00", bus.o_tdata);
        end
        checks++;
        if (bus.i_tready !== 1'b0) begin
            failures++; $display("FAIL reset_i_tready got=%b exp=0", bus.i_tready);
        end
        tick();
        reset        = 1'b1;
        bus.i_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.i_tready !== 1'b1) begin
            failures++; $display("FAIL release_i_tready got=%b exp=1", bus.i_tready);
        end
        tick();
    endtask

    task automatic test_alternating();
        bus.o_tready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            bus.i_tvalid = (k < 8);
            if (k < 8) bus.i_tdata = alt_in[k];
            @(negedge clk);
            if (k < 8) begin
                checks++;
                if (bus.i_tready !== 1'b1) begin
                    failures++; $display("FAIL alt_i_tready k=%0d got=%b exp=1", k, bus.i_tready);
                end
            end
            if (k > 0) begin
                checks++;
                if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== alt_exp[k-1]) begin
                    failures++;
                    $display("FAIL alt_out n=%0d got=%b/%h exp=1/%h", k-1, bus.o_tvalid, bus.o_tdata, alt_exp[k-1]);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.o_tvalid !== 1'b0) begin
            failures++; $display("FAIL alt_drain_o_tvalid got=%b exp=0", bus.o_tvalid);
        end
        tick();
    endtask

    task automatic test_step_wrap();
        clear = 1'b1;
        tick();
        clear        = 1'b0;
        bus.o_tready = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            bus.i_tvalid = (k < 8);
            if (k < 8) bus.i_tdata = step_in[k];
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 8'h7F) begin
                    failures++;
                    $display("FAIL step_out n=%0d got=%b/%h exp=1/7f", k-1, bus.o_tvalid, bus.o_tdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int in_idx;
        int out_idx;
        pulse_reset();
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
            bus.i_tvalid = (in_idx < 8);
            if (in_idx < 8) bus.i_tdata = alt_in[in_idx];
            bus.o_tready = !(cyc >= 3 && cyc < 6);
            @(negedge clk);
            if (!bus.o_tready) begin
                checks++;
                if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== alt_exp[out_idx] || bus.i_tready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%b/%h rdy=%b exp=1/%h rdy=0",
                             cyc, bus.o_tvalid, bus.o_tdata, bus.i_tready, alt_exp[out_idx]);
                end
            end
            if (bus.o_tvalid && bus.o_tready) begin
                checks++;
                if (bus.o_tdata !== alt_exp[out_idx]) begin
                    failures++;
                    $display("FAIL bp_out n=%0d got=%h exp=%h", out_idx, bus.o_tdata, alt_exp[out_idx]);
                end
                out_idx++;
            end
            if (bus.i_tvalid && bus.i_tready) in_idx++;
            tick();
        end
        checks++;
        if (out_idx != 8 || in_idx != 8) begin
            failures++; $display("FAIL bp_count got=%0d/%0d exp=8/8", in_idx, out_idx);
        end
        bus.i_tvalid = 1'b0;
        bus.o_tready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_tvalid !== 1'b0) begin
            failures++; $display("FAIL bp_no_dup got=%b exp=0", bus.o_tvalid);
        end
        tick();
    endtask

    task automatic test_clear();
        pulse_reset();
        bus.o_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_tvalid = 1'b1;
            bus.i_tdata  = alt_in[k];
            tick();
        end
        clear        = 1'b1;
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = 11'h123;
        @(negedge clk);
        checks++;
        if (bus.i_tready !== 1'b0) begin
            failures++; $display("FAIL clear_i_tready got=%b exp=0", bus.i_tready);
        end
        tick();
        clear        = 1'b0;
        bus.i_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_tvalid !== 1'b0) begin
            failures++; $display("FAIL clear_o_tvalid got=%b exp=0", bus.o_tvalid);
        end
        tick();
        for (int k = 0; k <= 8; k++) begin
            bus.i_tvalid = (k < 8);
            if (k < 8) bus.i_tdata = alt_in[k];
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== alt_exp[k-1]) begin
                    failures++;
                    $display("FAIL clear_replay n=%0d got=%b/%h exp=1/%h", k-1, bus.o_tvalid, bus.o_tdata, alt_exp[k-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.o_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_tvalid = 1'b1;
            bus.i_tdata  = alt_in[k];
            tick();
        end
        reset        = 1'b0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = alt_in[4];
        @(negedge clk);
        checks++;
        if (bus.i_tready !== 1'b0) begin
            failures++; $display("FAIL rstmid_i_tready0 got=%b exp=0", bus.i_tready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.o_tvalid !== 1'b0 || bus.i_tready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_hold got=%b/%b exp=0/0", bus.o_tvalid, bus.i_tready);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            bus.i_tvalid = (k < 8);
            if (k < 8) bus.i_tdata = alt_in[k];
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== alt_exp[k-1]) begin
                    failures++;
                    $display("FAIL rstmid_replay n=%0d got=%b/%h exp=1/%h", k-1, bus.o_tvalid, bus.o_tdata, alt_exp[k-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_ramp_random();
        int in_idx;
        int out_idx;
        int xv[NRAMP];
        int y;
        // Golden encoder: plain SIZE-window sum of the signed ramp, wrapped to IW.
        for (int n = 0; n < NRAMP; n++) begin
            ramp_exp[n] = 8'(n % 144);
            xv[n]       = (n % 144 >= 128) ? (n % 144) - 256 : (n % 144);
            y = 0;
            for (int k = 0; k < SIZE; k++) begin
                if (n - k >= 0) y += xv[n-k];
            end
            ramp_in[n] = IW'(y);
        end
        pulse_reset();
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 4000 && out_idx < NRAMP; cyc++) begin
            bus.i_tvalid = (in_idx < NRAMP) && ($urandom_range(0, 3) != 0);
            if (in_idx < NRAMP) bus.i_tdata = ramp_in[in_idx];
            bus.o_tready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (bus.o_tvalid && bus.o_tready) begin
                checks++;
                if (out_idx >= NRAMP) begin
                    failures++; $display("FAIL ramp_extra got=%h exp=none", bus.o_tdata);
                end else if (bus.o_tdata !== ramp_exp[out_idx]) begin
                    failures++;
                    $display("FAIL ramp_out n=%0d got=%h exp=%h", out_idx, bus.o_tdata, ramp_exp[out_idx]);
                end
                out_idx++;
            end
            if (bus.i_tvalid && bus.i_tready) in_idx++;
            tick();
        end
        checks++;
        if (out_idx != NRAMP) begin
            failures++; $display("FAIL ramp_count got=%0d exp=%0d", out_idx, NRAMP);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        clear        = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.o_tready = 1'b1;
        alt_in  = '{11'h07F, 11'h7FF, 11'h07E, 11'h7FE, 11'h07D, 11'h7FD, 11'h7FD, 11'h7FD};
        alt_exp = '{8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
        step_in = '{11'd127, 11'd254, 11'd381, 11'd508, 11'd635, 11'd762, 11'd762, 11'd762};
        test_reset();
        test_alternating();
        test_step_wrap();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_ramp_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
